// File: rtl/wb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_rx
// Brief    : UART receive half. Oversamples an asynchronous 8N1 line, deframes
//            each byte into a one-byte holding register read over a Wishbone
//            read-only slave port. Sticky framing-error and overrun flags.
// Revision : 1.0 - initial release
// ============================================================================
module wb_uart_rx #(
  parameter int TICKS_PER_BAUD = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       wb_stb_i,
  output logic       wb_ack_o,
  output logic [7:0] wb_dat_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  output logic       rx_ovr_o,
  input  logic       uart_rx
);

  // Baud counter must hold TICKS_PER_BAUD-1; mid-bit point of the start bit is HALF.
  localparam int                 c_CNT_W = (TICKS_PER_BAUD > 1) ? $clog2(TICKS_PER_BAUD) : 1;
  localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(TICKS_PER_BAUD / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  // Line synchronizer
  logic               r_sync1;
  logic               r_sync2;

  // Deframer
  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;

  // Holding register, flags and bus side
  logic [7:0]         r_hold;
  logic               r_valid;
  logic               r_ferr;
  logic               r_ovr;
  logic               r_ack;
  logic [7:0]         r_dat;

  logic               w_rx_s;
  logic               w_rd;
  logic               w_stop_smp;
  logic               w_deliver;
  logic               w_frame_err;
  logic               w_store;
  logic               w_overrun;

  assign w_rx_s      = r_sync2;

  // A read is accepted only while no ack is outstanding, so a held strobe
  // alternates accept / ack cycles.
  assign w_rd        = wb_stb_i & ~r_ack;

  // Stop bit is sampled at its centre; a high stop delivers, a low one is a framing error.
  assign w_stop_smp  = (r_state == S_STOP) && (r_cnt == c_LAST);
  assign w_deliver   = w_stop_smp & w_rx_s;
  assign w_frame_err = w_stop_smp & ~w_rx_s;

  // A delivered byte is kept if the register is empty or is being read this
  // cycle; otherwise it is dropped and flagged as an overrun.
  assign w_store     = w_deliver & (~r_valid | w_rd);
  assign w_overrun   = w_deliver & r_valid & ~w_rd;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receive state machine: start qualification, data shifting, stop check.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          // Re-check the line at the middle of the start bit to reject glitches.
          if (r_cnt == c_HALF) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          // LSB arrives first, so shift right and insert at the MSB.
          if (r_cnt == c_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_cnt == c_LAST) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WAIT_HIGH: begin
          // A held-low line (break) must return high before a new start is looked for.
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Holding register, sticky flags and Wishbone read response; set beats clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_hold  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_ack   <= 1'b0;
      r_dat   <= 8'h00;
    end else begin
      r_ack <= w_rd;

      // The read always returns the byte held before this edge.
      if (w_rd) begin
        r_dat <= r_valid ? r_hold : 8'h00;
      end

      if (w_store) begin
        r_hold  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_rd) begin
        r_valid <= 1'b0;
      end

      if (w_frame_err) begin
        r_ferr <= 1'b1;
      end else if (w_rd) begin
        r_ferr <= 1'b0;
      end

      if (w_overrun) begin
        r_ovr <= 1'b1;
      end else if (w_rd) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign wb_ack_o   = r_ack;
  assign wb_dat_o   = r_dat;
  assign rx_valid_o = r_valid;
  assign rx_ferr_o  = r_ferr;
  assign rx_ovr_o   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_uart_rx
// Brief    : Self-checking bench for wb_uart_rx: serial frame driver, byte
//            scoreboard, vector table plus hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_uart_rx;

  localparam int T    = 16;
  localparam int HALF = T / 2 - 1;
  localparam int LAT  = 3 + HALF + 9 * T;

  logic       clk = 1'b0;
  logic       rst;
  logic       stb;
  logic       rx;
  logic       ack;
  logic [7:0] dat;
  logic       valid;
  logic       ferr;
  logic       ovr;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  wb_uart_rx #(.TICKS_PER_BAUD(T)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_stb_i   (stb),
    .wb_ack_o   (ack),
    .wb_dat_o   (dat),
    .rx_valid_o (valid),
    .rx_ferr_o  (ferr),
    .rx_ovr_o   (ovr),
    .uart_rx    (rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one frame starting at the current negedge; line is left high.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (T) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (T) @(negedge clk);
    end
    rx = stop_bit;
    repeat (T) @(negedge clk);
    rx = 1'b1;
  endtask

  // One read; expected data comes from the scoreboard (0x00 when it is empty).
  task automatic do_read(input string name, output logic v_at_ack);
    logic [7:0] exp;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
    stb = 1'b1;
    @(negedge clk);
    check({name, " ack"}, ack, 1);
    check({name, " dat"}, dat, exp);
    v_at_ack = valid;
    stb = 1'b0;
    @(negedge clk);
    check({name, " ack pulse"}, ack, 0);
  endtask

  task automatic strobe_hold(input int n, input int exp_acks);
    int acks;
    acks = 0;
    stb  = 1'b1;
    repeat (n) begin
      @(negedge clk);
      acks += int'(ack);
    end
    stb = 1'b0;
    repeat (2) begin
      @(negedge clk);
      acks += int'(ack);
    end
    check($sformatf("strobe %0d acks", n), acks, exp_acks);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hC3, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    stb = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset ack", ack, 0);
    check("reset dat", dat, 8'h00);
    check("reset valid", valid, 0);
    check("reset ferr", ferr, 0);
    check("reset ovr", ovr, 0);

    // Latency of 0xA5 from first low edge to rx_valid_o
    sb_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin : mon_lat
        int n;
        n = 0;
        @(posedge clk);
        while (!valid && n < 400) begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end
        check("latency", n, LAT);
      end
    join
    repeat (2) @(negedge clk);
    do_read("a5 read", v);
    check("a5 valid after read", v, 0);

    // Short low glitch is rejected
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch valid", valid, 0);
    check("glitch ferr", ferr, 0);
    check("glitch ovr", ovr, 0);

    // Bad stop bit followed by a break, then a good frame
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("break ferr", ferr, 1);
    check("break valid", valid, 0);
    check("break ovr", ovr, 0);
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    repeat (4) @(negedge clk);
    check("post-break valid", valid, 1);
    do_read("11 read", v);
    check("ferr cleared by read", ferr, 0);

    // Overrun: second byte dropped
    sb_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    repeat (4) @(negedge clk);
    check("ovr set", ovr, 1);
    check("ovr valid", valid, 1);
    do_read("ovr read", v);
    check("ovr cleared", ovr, 0);
    check("ovr valid cleared", valid, 0);

    // Read accepted on the exact delivery cycle
    sb_q.push_back(8'h44);
    send_frame(8'h44, 1'b1);
    repeat (4) @(negedge clk);
    check("44 held", valid, 1);
    sb_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1);
      begin : mon_sim
        logic [7:0] exp;
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        exp = sb_q.pop_front();
        check("sim ack", ack, 1);
        check("sim dat", dat, exp);
        check("sim valid", valid, 1);
        check("sim ovr", ovr, 0);
        stb = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("sim ovr later", ovr, 0);
    do_read("55 read", v);
    check("55 ovr", ovr, 0);

    // Held strobe: ceil(N/2) acks
    strobe_hold(2, 1);
    strobe_hold(3, 2);

    // Table of frames
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].exp_valid) sb_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d valid", i), valid, vecs[i].exp_valid);
      check($sformatf("vec%0d ferr", i), ferr, vecs[i].exp_ferr);
      do_read($sformatf("vec%0d", i), v);
      check($sformatf("vec%0d ferr after read", i), ferr, 0);
      check($sformatf("vec%0d valid after read", i), valid, 0);
    end

    // Reset during data bit 4 of a frame with a framing error pending
    send_frame(8'h81, 1'b0);
    repeat (4) @(negedge clk);
    check("pre-reset ferr", ferr, 1);
    fork
      send_frame(8'hF0, 1'b1);
      begin : mon_rst
        repeat (T * 5 + T / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst ack", ack, 0);
        check("midrst dat", dat, 8'h00);
        check("midrst valid", valid, 0);
        check("midrst ferr", ferr, 0);
        check("midrst ovr", ovr, 0);
      end
    join
    repeat (200) @(negedge clk);
    check("midrst no byte", valid, 0);
    check("midrst no ferr", ferr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
